// File: rtl/debug_dump_seq.sv
// Debug dump sequencer: on trigger, freezes the PC and streams header, PC, registers,
// a memory window and pipeline-latch signals to a UART TX. Optional checksum word: DUMP_CHECKSUM_EN.
module debug_dump_seq #(
    parameter int unsigned               DATA_W     = 32,
    parameter int unsigned               NUM_REGS   = 32,
    parameter int unsigned               ADDR_W     = 32,
    parameter int unsigned               MAX_MEM    = 20,
    parameter int unsigned               NUM_STAGES = 5,
    parameter logic [4*NUM_STAGES-1:0]   STAGE_SIGS = 20'h25662
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_mode,
    input  logic [31:0]       trig_pc,
    input  logic              dbg_req,
    input  logic              auto_rearm,
    input  logic [ADDR_W-1:0] mem_base,
    input  logic [15:0]       mem_words,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] latch_data,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [6:0]        latch_sel,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              stop_pc,
    output logic              debug_on,
    output logic              halted
);

    typedef enum logic [3:0] {
        IDLE, ARMED, HDR, PC, REG, MEM, LATCH, WAIT, FINISH, HALT
`ifdef DUMP_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    // Lowest stage index >= from with a non-zero signal count; NUM_STAGES if none.
    function automatic int unsigned first_stage(input int unsigned from);
        int unsigned r;
        r = NUM_STAGES;
        for (int unsigned i = NUM_STAGES; i > 0; i--) begin
            if ((i - 1) >= from && STAGE_SIGS[4*(i-1) +: 4] != 4'd0) r = i - 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] sigs_of(input logic [2:0] s);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (3'(i) == s) r = STAGE_SIGS[4*i +: 4];
        end
        return r;
    endfunction

    localparam int unsigned FIRST_STAGE = first_stage(0);
    localparam bit          HAS_LATCH   = (FIRST_STAGE < NUM_STAGES);
`ifdef DUMP_CHECKSUM_EN
    localparam state_t AFTER_LATCH = CSUM;
`else
    localparam state_t AFTER_LATCH = FINISH;
`endif
    localparam state_t AFTER_MEM = HAS_LATCH ? LATCH : AFTER_LATCH;

    state_t            state, state_n, ret, ret_n;
    logic              tx_start_n, stop_pc_n, debug_on_n, halted_n, issue;
    logic [DATA_W-1:0] tx_data_n, word;
    logic [ADDR_W-1:0] reg_addr_n, mem_addr_n;
    logic [6:0]        latch_sel_n;
    logic [15:0]       mem_cnt, mem_cnt_n, mem_left, mem_left_n;
    int unsigned       nxt_stage;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum, csum_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ret       <= IDLE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            reg_addr  <= '0;
            mem_addr  <= '0;
            latch_sel <= '0;
            stop_pc   <= 1'b1;
            debug_on  <= 1'b0;
            halted    <= 1'b0;
            mem_cnt   <= '0;
            mem_left  <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
            reg_addr  <= reg_addr_n;
            mem_addr  <= mem_addr_n;
            latch_sel <= latch_sel_n;
            stop_pc   <= stop_pc_n;
            debug_on  <= debug_on_n;
            halted    <= halted_n;
            mem_cnt   <= mem_cnt_n;
            mem_left  <= mem_left_n;
`ifdef DUMP_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        ret_n       = ret;
        tx_start_n  = 1'b0;
        tx_data_n   = tx_data;
        reg_addr_n  = reg_addr;
        mem_addr_n  = mem_addr;
        latch_sel_n = latch_sel;
        stop_pc_n   = stop_pc;
        debug_on_n  = debug_on;
        halted_n    = halted;
        mem_cnt_n   = mem_cnt;
        mem_left_n  = mem_left;
        issue       = 1'b0;
        word        = '0;
        nxt_stage   = 0;
`ifdef DUMP_CHECKSUM_EN
        csum_n      = csum;
`endif
        case (state)
            IDLE: begin
                state_n   = ARMED;
                stop_pc_n = 1'b0;
            end
            ARMED: begin
                if (trig_mode ? dbg_req : (in_pc == trig_pc)) begin
                    stop_pc_n  = 1'b1;
                    debug_on_n = 1'b1;
                    mem_cnt_n  = (mem_words > 16'(MAX_MEM)) ? 16'(MAX_MEM) : mem_words;
                    state_n    = HDR;
                end
            end
            HDR: begin
                issue       = 1'b1;
                word[31:0]  = {8'hA5, 8'(NUM_REGS), mem_cnt};
`ifdef DUMP_CHECKSUM_EN
                word[31]    = 1'b1;
`endif
                ret_n       = PC;
            end
            PC: begin
                issue      = 1'b1;
                word[31:0] = in_pc;
                ret_n      = REG;
            end
            REG: begin
                issue = 1'b1;
                word  = reg_data;
                if (reg_addr == ADDR_W'(NUM_REGS - 1)) begin
                    reg_addr_n = '0;
                    ret_n      = (mem_cnt != '0) ? MEM : AFTER_MEM;
                end else begin
                    reg_addr_n = reg_addr + ADDR_W'(1);
                    ret_n      = REG;
                end
            end
            MEM: begin
                issue = 1'b1;
                word  = mem_data;
                if (mem_left == 16'd1) begin
                    ret_n = AFTER_MEM;
                end else begin
                    mem_addr_n = mem_addr + ADDR_W'(1);
                    mem_left_n = mem_left - 16'd1;
                    ret_n      = MEM;
                end
            end
            LATCH: begin
                issue = 1'b1;
                word  = latch_data;
                ret_n = LATCH;
                if ((latch_sel[3:0] + 4'd1) == sigs_of(latch_sel[6:4])) begin
                    nxt_stage = first_stage(32'(latch_sel[6:4]) + 32'd1);
                    if (nxt_stage >= NUM_STAGES) begin
                        latch_sel_n = '0;
                        ret_n       = AFTER_LATCH;
                    end else begin
                        latch_sel_n = {3'(nxt_stage), 4'd0};
                    end
                end else begin
                    latch_sel_n = {latch_sel[6:4], latch_sel[3:0] + 4'd1};
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                issue = 1'b1;
                word  = csum;
                ret_n = FINISH;
            end
`endif
            WAIT: begin
                // The cycle tx_start is high cannot complete the word just issued.
                if (!tx_start && tx_ready) state_n = ret;
            end
            FINISH: begin
                debug_on_n = 1'b0;
                if (auto_rearm) begin
                    stop_pc_n = 1'b0;
                    state_n   = ARMED;
                end else begin
                    halted_n = 1'b1;
                    state_n  = HALT;
                end
            end
            HALT: begin
                if (dbg_req) begin
                    halted_n  = 1'b0;
                    stop_pc_n = 1'b0;
                    state_n   = ARMED;
                end
            end
            default: state_n = IDLE;
        endcase

        // Section entry side effects are applied on the issue that first selects the section.
        if (issue) begin
            tx_start_n = 1'b1;
            tx_data_n  = word;
            state_n    = WAIT;
`ifdef DUMP_CHECKSUM_EN
            csum_n     = (state == HDR) ? word : (csum ^ word);
`endif
            if (ret_n == MEM && state != MEM) begin
                mem_addr_n = mem_base;
                mem_left_n = mem_cnt;
            end
            if (ret_n == LATCH && state != LATCH) latch_sel_n = {3'(FIRST_STAGE), 4'd0};
        end
    end

endmodule

// File: tb/tb_debug_dump_seq.sv
// Directed self-checking bench for debug_dump_seq (default parameters).
module tb_debug_dump_seq;

    logic        clk, rst, trig_mode, dbg_req, auto_rearm, tx_ready;
    logic [31:0] trig_pc, mem_base, in_pc;
    logic [15:0] mem_words;
    logic [31:0] reg_data, mem_data, latch_data;
    logic [31:0] reg_addr, mem_addr, tx_data;
    logic [6:0]  latch_sel;
    logic        tx_start, stop_pc, debug_on, halted;

    int errors = 0;
    int checks = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int cyc = 0, last_cyc = 0, min_gap = 1000, max_gap = 0;
    bit early = 1'b0;
    int stage_sigs[5] = '{2, 6, 6, 5, 2};
    logic [31:0] saved;

    debug_dump_seq dut (
        .clk(clk), .rst(rst), .trig_mode(trig_mode), .trig_pc(trig_pc), .dbg_req(dbg_req),
        .auto_rearm(auto_rearm), .mem_base(mem_base), .mem_words(mem_words), .in_pc(in_pc),
        .reg_data(reg_data), .mem_data(mem_data), .latch_data(latch_data), .tx_ready(tx_ready),
        .reg_addr(reg_addr), .mem_addr(mem_addr), .latch_sel(latch_sel), .tx_start(tx_start),
        .tx_data(tx_data), .stop_pc(stop_pc), .debug_on(debug_on), .halted(halted)
    );

    function automatic logic [31:0] reg_val(input logic [31:0] a);
        return 32'h1000_0000 ^ a;
    endfunction
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return ~a;
    endfunction
    function automatic logic [31:0] latch_val(input logic [6:0] s);
        return 32'h5A00_0000 | {25'd0, s};
    endfunction

    assign reg_data   = reg_val(reg_addr);
    assign mem_data   = mem_val(mem_addr);
    assign latch_data = latch_val(latch_sel);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        cyc++;
        if (tx_start === 1'b1) begin
            got.push_back(tx_data);
            if (got.size() > 1) begin
                if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                if (cyc - last_cyc > max_gap) max_gap = cyc - last_cyc;
            end
            last_cyc = cyc;
        end
    end

    // UART model: word done 5 cycles after tx_start; optionally also asserts ready during tx_start.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (early) tx_ready = 1'b1;
                @(negedge clk);
                tx_ready = 1'b0;
                repeat (4) @(negedge clk);
                tx_ready = 1'b1;
                @(negedge clk);
                tx_ready = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic clear_capture();
        got.delete();
        min_gap = 1000;
        max_gap = 0;
    endtask

    task automatic build(input logic [31:0] pc, input logic [31:0] base, input int cnt);
        logic [31:0] x;
        exp_q.delete();
        exp_q.push_back({8'hA5, 8'd32, 16'(cnt)});
`ifdef DUMP_CHECKSUM_EN
        exp_q[0][31] = 1'b1;
`endif
        exp_q.push_back(pc);
        for (int i = 0; i < 32; i++) exp_q.push_back(reg_val(32'(i)));
        for (int i = 0; i < cnt; i++) exp_q.push_back(mem_val(base + 32'(i)));
        for (int s = 0; s < 5; s++)
            for (int g = 0; g < stage_sigs[s]; g++) exp_q.push_back(latch_val({3'(s), 4'(g)}));
`ifdef DUMP_CHECKSUM_EN
        x = '0;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic compare_frame(input string tag);
        check({tag, " len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s w%0d", tag, i), got[i], exp_q[i]);
        check({tag, " gap_min"}, 32'(min_gap), 32'd7);
        check({tag, " gap_max"}, 32'(max_gap), 32'd7);
    endtask

    task automatic wait_frame_end(input string tag);
        int n;
        n = 0;
        while (debug_on !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, " started"}, 32'(debug_on), 32'd1);
        n = 0;
        while (debug_on !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check({tag, " ended"}, 32'(debug_on), 32'd0);
    endtask

    task automatic pulse_req();
        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; trig_mode = 1'b0; trig_pc = 32'd16; dbg_req = 1'b0; auto_rearm = 1'b0;
        mem_base = 32'h100; mem_words = 16'd20; in_pc = 32'd0;
        repeat (2) @(negedge clk);
        check("rst stop_pc", 32'(stop_pc), 32'd1);
        check("rst debug_on", 32'(debug_on), 32'd0);
        check("rst tx_start", 32'(tx_start), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst reg_addr", reg_addr, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst latch_sel", 32'(latch_sel), 32'd0);
        check("rst tx_data", tx_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("armed stop_pc", 32'(stop_pc), 32'd0);

        // PC-match frame; a dbg_req mid-frame must not restart it.
        in_pc = 32'd8;
        repeat (3) @(negedge clk);
        check("no_trig debug_on", 32'(debug_on), 32'd0);
        clear_capture();
        in_pc = 32'd16;
        repeat (60) @(negedge clk);
        pulse_req();
        wait_frame_end("pcm");
        build(32'd16, 32'h100, 20);
        compare_frame("pcm");
        check("pcm hdr", got.size() > 0 ? got[0] : 32'hx, 32'hA520_0014);
        check("pcm halted", 32'(halted), 32'd1);
        check("pcm stop_pc", 32'(stop_pc), 32'd1);
        check("pcm latch_sel", 32'(latch_sel), 32'd0);
        check("pcm reg_addr", reg_addr, 32'd0);
        check("pcm mem_addr", mem_addr, 32'h113);
        in_pc = 32'd0;
        pulse_req();
        check("rearm halted", 32'(halted), 32'd0);
        check("rearm stop_pc", 32'(stop_pc), 32'd0);

        // Clamp to 20 words, address wrap, ready asserted during tx_start.
        trig_mode = 1'b1; mem_words = 16'd100; mem_base = 32'hFFFF_FFF8; in_pc = 32'h444;
        early = 1'b1;
        clear_capture();
        pulse_req();
        wait_frame_end("clamp");
        build(32'h444, 32'hFFFF_FFF8, 20);
        compare_frame("clamp");
        check("clamp mem_addr", mem_addr, 32'h0000_000B);
        early = 1'b0;
        pulse_req();

        // Zero memory words: 55-word frame, mem_addr untouched.
        mem_words = 16'd0; mem_base = 32'h200;
        saved = mem_addr;
        clear_capture();
        pulse_req();
        wait_frame_end("zero");
        build(32'h444, 32'h200, 0);
        compare_frame("zero");
        check("zero mem_addr", mem_addr, saved);
        pulse_req();

        // Auto re-arm with a constantly matching PC: back-to-back frames.
        trig_mode = 1'b0; in_pc = 32'd16; auto_rearm = 1'b1; mem_words = 16'd2; mem_base = 32'h40;
        clear_capture();
        wait_frame_end("auto1");
        build(32'd16, 32'h40, 2);
        compare_frame("auto1");
        check("auto1 halted", 32'(halted), 32'd0);
        clear_capture();
        auto_rearm = 1'b0;
        wait_frame_end("auto2");
        compare_frame("auto2");
        check("auto2 halted", 32'(halted), 32'd1);
        in_pc = 32'd0;
        pulse_req();

        // Reset during the register section.
        trig_mode = 1'b1;
        clear_capture();
        pulse_req();
        for (int n = 0; n < 300 && got.size() < 11; n++) @(negedge clk);
        check("midrst reached word10", 32'(got.size() >= 11), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst tx_start", 32'(tx_start), 32'd0);
        check("midrst stop_pc", 32'(stop_pc), 32'd1);
        check("midrst debug_on", 32'(debug_on), 32'd0);
        check("midrst reg_addr", reg_addr, 32'd0);
        @(negedge clk);
        check("midrst armed stop_pc", 32'(stop_pc), 32'd0);
        repeat (10) @(negedge clk);
        check("midrst no restart", 32'(debug_on), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
